// File: rtl/uart_receiver.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling FSM with
// false-start rejection, parity/stop checks and a receive FIFO with sticky overrun.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_data,
    input  logic                          rhr_read,
    input  logic                          clr_status,
    output logic                          rx_status,
    output logic [DATA_BITS-1:0]          RHR,
    output logic                          rhr_valid,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW   = $clog2(OVERSAMPLE);
    localparam int BW   = $clog2(DATA_BITS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
    localparam int EW   = DATA_BITS + 2;
    localparam logic [CW-1:0] HALF  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
    localparam logic          ODD   = (PARITY == 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic                 sync_r, rxs_r, rxs_d_r;
    state_t               state_r, state_nx;
    logic [CW-1:0]        cnt_r, cnt_nx;
    logic [BW-1:0]        bits_r, bits_nx;
    logic [DATA_BITS-1:0] shift_r, shift_nx;
    logic                 perr_r, perr_nx;
    logic                 push_s, ferr_s;
    logic [EW-1:0]        mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [NW-1:0]        count_r;
    logic                 overrun_r;
    logic                 empty_s, full_s, pop_s, wr_s, drop_s;
    logic [EW-1:0]        head_s;

    // Synchroniser plus one delayed copy for start-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r  <= 1'b1;
            rxs_r   <= 1'b1;
            rxs_d_r <= 1'b1;
        end else begin
            sync_r  <= rx_data;
            rxs_r   <= sync_r;
            rxs_d_r <= rxs_r;
        end
    end

    // Receive FSM state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            bits_r  <= {BW{1'b0}};
            shift_r <= {DATA_BITS{1'b0}};
            perr_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            bits_r  <= bits_nx;
            shift_r <= shift_nx;
            perr_r  <= perr_nx;
        end
    end

    // Next-state logic; every sample point is at counter terminal value
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r + CW'(1);
        bits_nx  = bits_r;
        shift_nx = shift_r;
        perr_nx  = perr_r;
        push_s   = 1'b0;
        ferr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nx = {CW{1'b0}};
                if (rxs_d_r && !rxs_r) begin
                    state_nx = START;
                    bits_nx  = {BW{1'b0}};
                    perr_nx  = 1'b0;
                end else begin
                    state_nx = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF) begin
                    cnt_nx   = {CW{1'b0}};
                    state_nx = rxs_r ? IDLE : DATA;
                end else begin
                    state_nx = START;
                end
            end
            DATA: begin
                if (cnt_r == LAST) begin
                    cnt_nx   = {CW{1'b0}};
                    shift_nx = {rxs_r, shift_r[DATA_BITS-1:1]};
                    if (bits_r == BLAST) begin
                        bits_nx  = {BW{1'b0}};
                        state_nx = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bits_nx  = bits_r + BW'(1);
                    end
                end else begin
                    state_nx = DATA;
                end
            end
            PAR: begin
                if (cnt_r == LAST) begin
                    cnt_nx   = {CW{1'b0}};
                    perr_nx  = ((^shift_r) ^ rxs_r) != ODD;
                    state_nx = STOP;
                end else begin
                    state_nx = PAR;
                end
            end
            STOP: begin
                if (cnt_r == LAST) begin
                    cnt_nx   = {CW{1'b0}};
                    push_s   = 1'b1;
                    ferr_s   = !rxs_r;
                    state_nx = IDLE;
                end else begin
                    state_nx = STOP;
                end
            end
            default: begin
                cnt_nx   = {CW{1'b0}};
                state_nx = IDLE;
            end
        endcase
    end

    assign empty_s = (count_r == {NW{1'b0}});
    assign full_s  = (count_r == NW'(FIFO_DEPTH));
    assign pop_s   = rhr_read && !empty_s;
    // A pop on the same edge frees the slot the push needs
    assign wr_s    = push_s && (!full_s || pop_s);
    assign drop_s  = push_s && full_s && !pop_s;

    // FIFO storage; contents are only observable through the masked head
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= {shift_r, perr_r, ferr_s};
        end
    end

    // FIFO pointers, occupancy and sticky overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {NW{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            if (wr_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + NW'(1);
                2'b01:   count_r <= count_r - NW'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) overrun_r <= 1'b1;
            else if (clr_status) overrun_r <= 1'b0;
        end
    end

    assign head_s     = empty_s ? {EW{1'b0}} : mem_r[rd_ptr_r];
    assign RHR        = head_s[EW-1:2];
    assign parity_err = head_s[1];
    assign frame_err  = head_s[0];
    assign rhr_valid  = !empty_s;
    assign overrun    = overrun_r;
    assign fifo_count = count_r;
    assign rx_status  = (state_r != IDLE);

endmodule
